calc_seq_ctrl: RTL and testbench
================================

Name: calc_seq_ctrl

Overview:
- Front-end controller for the float calculator ALU.
- Debounces the raw push buttons and edits the 64-bit operands A and B one nibble at a time under a cursor.
- Issues one operation to the multi-cycle float unit over a req/ack + done handshake, captures the result and drives the display page and blink selection.
- Sits between the board buttons/switches, the float ALU and the 7-segment display driver.

Parameters:
DB_LIMIT, 1000000, consecutive stable samples required before a button level is accepted (10 ms at 100 MHz).
DB_CNT_W, 20, width of the debounce counter; must satisfy 2**DB_CNT_W > DB_LIMIT.
ALU_TIMEOUT, 255, maximum cycles to wait for alu_done before flagging an error.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
btn_left  in  1  raw button: move cursor down one nibble
btn_right  in  1  raw button: move cursor up one nibble
btn_inc  in  1  raw button: increment nibble under cursor
btn_go  in  1  raw button: start operation
mode  in  2  00 edit A, 01 edit B, 10 show result, 11 show result
op_sel  in  2  00 add, 01 sub, 10 mul, 11 div
alu_ack  in  1  float unit accepted request
alu_done  in  1  one-cycle pulse, alu_result valid
alu_result  in  64  float unit result
a_op  out  64  operand A
b_op  out  64  operand B
alu_req  out  1  request, held until ack
alu_op  out  2  op latched at go
result  out  64  last captured result
disp_data  out  64  A, B or result per mode
disp_page  out  2  which 16-bit window is shown (cursor[3:2])
blink  out  4  one-hot digit blink within the page
busy  out  1  high in ISSUE/WAIT
err  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst_n=0):
  - a_op=64'hFEDCBA9876543210, b_op=64'h0123456789ABCDEF, result=0, cursor=4'h1, alu_op=0.
  - alu_req=0, err=0, state=IDLE, debouncers cleared (stable level 0, count 0).
- Debounce:
  - 2-FF synchronizer per button, then a counter that resets whenever the input differs from the stable level.
  - The stable level flips when the count reaches DB_LIMIT.
  - A one-cycle press pulse is emitted on the stable 0->1 edge.
  - Latency from raw edge to pulse is 2+DB_LIMIT cycles.
- Editing is allowed only in IDLE, SHOW or ERR, and only with mode=00 (A) or 01 (B):
  - inc: the nibble at cursor is incremented mod 16, with no carry into the next nibble.
  - left: cursor-1; right: cursor+1. Both wrap across 0..15.
  - left and right pulses in the same cycle: no cursor move.
  - inc together with a move in the same cycle: inc applies to the old cursor and the move takes effect the same cycle.
  - Cursor moves also happen in mode 10/11; inc is ignored there.
- State machine: IDLE, ISSUE, WAIT, SHOW, ERR.
  - IDLE/SHOW/ERR + go pulse: latch op_sel into alu_op, clear err, go to ISSUE. Any edit pulse in that same cycle is dropped.
  - ISSUE: alu_req=1. When alu_ack=1, go to WAIT; alu_req drops the next cycle.
  - WAIT:
    - alu_done=1: result<=alu_result, go to SHOW.
    - A counter starts at 0 on entry. When the count reaches ALU_TIMEOUT without alu_done, set err=1 and go to ERR; result is unchanged.
    - alu_done on the same cycle the count reaches ALU_TIMEOUT: done wins.
  - ISSUE/WAIT: a_op and b_op are frozen, button pulses are ignored, busy=1.
  - alu_done outside WAIT is ignored.
  - Reset mid-operation returns to IDLE with alu_req=0 immediately.
- Display outputs (combinational from registers):
  - disp_data = a_op (mode 00), b_op (mode 01), result (mode 1x).
  - disp_page = cursor[3:2].
  - blink = 1<<cursor[1:0] when mode[1]=0 and the state is not ISSUE/WAIT; otherwise 4'b0000.

Optional Feature:
CALC_CARRY_EN:
- Defined: inc adds 64'h1<<(4*cursor) to the selected operand as a full 64-bit add. Carries ripple into higher nibbles; overflow out of bit 63 is discarded.
- Undefined: isolated per-nibble wrap as described in Behaviour.

Decomposition:
- Package calc_pkg:
  - state enum (IDLE, ISSUE, WAIT, SHOW, ERR).
  - op codes OP_ADD/OP_SUB/OP_MUL/OP_DIV.
  - mode codes.
  - reset constants A_RST, B_RST, CURSOR_RST.
- Sub-module btn_debounce: parameters DB_LIMIT and DB_CNT_W; ports clk, rst_n, raw, level, press. Instantiated four times.

Test Plan:
- Use DB_LIMIT=4 for all scenarios.
- Bounce: btn_inc toggles every cycle for 3 cycles, then stays high 8 cycles -> exactly one press; with mode=00 and cursor=1, a_op becomes 64'hFEDCBA9876543220.
- Wrap: from reset, 2 left presses -> cursor=4'hF, disp_page=3, blink=4'b1000. 1 right press -> cursor=0. Left+right in the same cycle -> no change.
- Nibble overflow: mode=01, cursor=0, 2 inc presses from reset (nibble F) -> b_op=64'h0123456789ABCDE1. With CALC_CARRY_EN the same stimulus gives 64'h0123456789ABCDF1.
- Handshake: op_sel=10, go; ack delayed 3 cycles; done 5 cycles after ack with alu_result=64'h4000000000000000.
  - alu_req stays high 3 cycles then drops; busy=1 throughout ISSUE/WAIT; inc presses during busy leave a_op unchanged.
  - result=64'h4000000000000000, state=SHOW, alu_op=2'b10.
- Timeout: go, ack, no done -> err=1 and state=ERR after ALU_TIMEOUT cycles, result unchanged. A second go clears err and re-issues.
- Async reset asserted in WAIT -> alu_req=0, state=IDLE, operands back to their reset values with no clock edge required.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator front-end controller.
// CALC_CARRY_EN switches nibble increment from isolated wrap to a full 64-bit add.
package calc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StShow,
        StErr
    } state_e;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] MODE_A   = 2'b00;
    localparam logic [1:0] MODE_B   = 2'b01;
    localparam logic [1:0] MODE_RES = 2'b10;

    localparam logic [63:0] A_RST      = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] B_RST      = 64'h0123_4567_89AB_CDEF;
    localparam logic [3:0]  CURSOR_RST = 4'h1;

    function automatic logic [63:0] nibble_inc(input logic [63:0] val, input logic [3:0] idx);
`ifdef CALC_CARRY_EN
        return val + (64'h1 << {idx, 2'b00});
`else
        logic [63:0] r;
        r = val;
        r[{idx, 2'b00} +: 4] = val[{idx, 2'b00} +: 4] + 4'd1;
        return r;
`endif
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: 2-FF synchronizer, stability counter, registered press pulse
// on each accepted 0->1 transition of the stable level.
module btn_debounce #(
    parameter int unsigned DB_LIMIT = 1000000,
    parameter int unsigned DB_CNT_W = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_LIMIT - 1);

    logic                sync_q1;
    logic                sync_q2;
    logic [DB_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt_q   <= '0;
            level   <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            press   <= 1'b0;
            if (sync_q2 == level) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                // DB_LIMIT consecutive differing samples: accept the new level.
                level <= sync_q2;
                press <= sync_q2;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator front-end: debounced operand editing, float-unit req/ack/done sequencing
// and display selection. Define CALC_CARRY_EN for carrying nibble increments.
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned DB_LIMIT    = 1000000,
    parameter int unsigned DB_CNT_W    = 20,
    parameter int unsigned ALU_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_inc,
    input  logic        btn_go,
    input  logic [1:0]  mode,
    input  logic [1:0]  op_sel,
    input  logic        alu_ack,
    input  logic        alu_done,
    input  logic [63:0] alu_result,
    output logic [63:0] a_op,
    output logic [63:0] b_op,
    output logic        alu_req,
    output logic [1:0]  alu_op,
    output logic [63:0] result,
    output logic [63:0] disp_data,
    output logic [1:0]  disp_page,
    output logic [3:0]  blink,
    output logic        busy,
    output logic        err
);

    localparam int unsigned TO_W = $clog2(ALU_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ALU_TIMEOUT);

    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic       unused_levels;

    assign btn_raw       = {btn_go, btn_inc, btn_right, btn_left};
    assign unused_levels = ^btn_level;

    for (genvar i = 0; i < 4; i++) begin : g_db
        btn_debounce #(
            .DB_LIMIT(DB_LIMIT),
            .DB_CNT_W(DB_CNT_W)
        ) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (btn_raw[i]),
            .level(btn_level[i]),
            .press(btn_press[i])
        );
    end

    logic left_p, right_p, inc_p, go_p;
    assign left_p  = btn_press[0];
    assign right_p = btn_press[1];
    assign inc_p   = btn_press[2];
    assign go_p    = btn_press[3];

    state_e          state_q;
    logic [3:0]      cursor_q;
    logic [TO_W-1:0] wait_cnt_q;
    logic            edit_en;

    // A go pulse takes priority over any edit arriving in the same cycle.
    assign edit_en = (state_q == StIdle || state_q == StShow || state_q == StErr) && !go_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_op     <= A_RST;
            b_op     <= B_RST;
            cursor_q <= CURSOR_RST;
        end else if (edit_en) begin
            if (inc_p && mode == MODE_A) begin
                a_op <= nibble_inc(a_op, cursor_q);
            end
            if (inc_p && mode == MODE_B) begin
                b_op <= nibble_inc(b_op, cursor_q);
            end
            if (left_p && !right_p) begin
                cursor_q <= cursor_q - 4'd1;
            end else if (right_p && !left_p) begin
                cursor_q <= cursor_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            alu_req    <= 1'b0;
            alu_op     <= OP_ADD;
            result     <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            case (state_q)
                StIdle, StShow, StErr: begin
                    if (go_p) begin
                        alu_op  <= op_sel;
                        err     <= 1'b0;
                        alu_req <= 1'b1;
                        busy    <= 1'b1;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (alu_ack) begin
                        alu_req    <= 1'b0;
                        wait_cnt_q <= '0;
                        state_q    <= StWait;
                    end
                end
                StWait: begin
                    // Done is checked first so it wins over a coincident timeout.
                    if (alu_done) begin
                        result  <= alu_result;
                        busy    <= 1'b0;
                        state_q <= StShow;
                    end else if (wait_cnt_q == TO_LAST) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StErr;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: begin
                    alu_req <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        disp_data = result;
        if (mode == MODE_A) begin
            disp_data = a_op;
        end else if (mode == MODE_B) begin
            disp_data = b_op;
        end
    end

    assign disp_page = cursor_q[3:2];
    assign blink     = (!mode[1] && !busy) ? (4'b0001 << cursor_q[1:0]) : 4'b0000;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Self-checking bench for calc_seq_ctrl with a short debounce window and a
// behavioural operand/cursor/result model.
module tb_calc_seq_ctrl;

    localparam int unsigned DBL = 4;
    localparam int unsigned DBW = 3;
    localparam int unsigned TMO = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_left, btn_right, btn_inc, btn_go;
    logic [1:0]  mode, op_sel;
    logic        alu_ack, alu_done;
    logic [63:0] alu_result;
    logic [63:0] a_op, b_op, result, disp_data;
    logic        alu_req, busy, err;
    logic [1:0]  alu_op, disp_page;
    logic [3:0]  blink;

    calc_seq_ctrl #(
        .DB_LIMIT(DBL),
        .DB_CNT_W(DBW),
        .ALU_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_left(btn_left), .btn_right(btn_right), .btn_inc(btn_inc), .btn_go(btn_go),
        .mode(mode), .op_sel(op_sel),
        .alu_ack(alu_ack), .alu_done(alu_done), .alu_result(alu_result),
        .a_op(a_op), .b_op(b_op), .alu_req(alu_req), .alu_op(alu_op), .result(result),
        .disp_data(disp_data), .disp_page(disp_page), .blink(blink), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [63:0] a_m, b_m, res_m;
    int          cur_m;

    function automatic logic [63:0] inc_model(input logic [63:0] v, input int c);
`ifdef CALC_CARRY_EN
        return v + (64'd1 << (4 * c));
`else
        logic [63:0] d;
        d = (v >> (4 * c)) & 64'hF;
        return v - (d << (4 * c)) + (((d + 64'd1) % 64'd16) << (4 * c));
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) tick();
    endtask

    task automatic hold_buttons(input logic l, input logic r, input logic i, input logic g);
        btn_left = l; btn_right = r; btn_inc = i; btn_go = g;
        cyc(DBL + 3);
        btn_left = 0; btn_right = 0; btn_inc = 0; btn_go = 0;
        cyc(DBL + 3);
    endtask

    task automatic do_reset();
        rst_n = 0;
        btn_left = 0; btn_right = 0; btn_inc = 0; btn_go = 0;
        mode = 2'b00; op_sel = 2'b00; alu_ack = 0; alu_done = 0; alu_result = '0;
        cyc(2);
        rst_n = 1;
        cyc(1);
        a_m = 64'hFEDCBA9876543210; b_m = 64'h0123456789ABCDEF; res_m = '0; cur_m = 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 9;
        if (a_op !== a_m) begin errors++; $display("FAIL reset_a: got %h want %h", a_op, a_m); end
        if (b_op !== b_m) begin errors++; $display("FAIL reset_b: got %h want %h", b_op, b_m); end
        if (result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        if (alu_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", alu_req); end
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (alu_op !== 2'b00) begin errors++; $display("FAIL reset_op: got %b want 00", alu_op); end
        if (disp_data !== a_m) begin errors++; $display("FAIL reset_disp: got %h want %h", disp_data, a_m); end
        if ({disp_page, blink} !== {2'd0, 4'b0010}) begin
            errors++; $display("FAIL reset_cursor: got page %0d blink %b want 0 0010", disp_page, blink);
        end
    endtask

    task automatic test_bounce();
        mode = 2'b00;
        btn_inc = 1; tick(); btn_inc = 0; tick(); btn_inc = 1; tick();
        cyc(8);
        btn_inc = 0;
        cyc(DBL + 4);
        a_m = inc_model(a_m, cur_m);
        checks += 2;
        if (a_op !== 64'hFEDCBA9876543220) begin
            errors++; $display("FAIL bounce_a: got %h want FEDCBA9876543220", a_op);
        end
        if (a_op !== a_m) begin errors++; $display("FAIL bounce_model: got %h want %h", a_op, a_m); end
    endtask

    task automatic test_wrap();
        do_reset();
        hold_buttons(1, 0, 0, 0);
        hold_buttons(1, 0, 0, 0);
        checks++;
        if ({disp_page, blink} !== {2'd3, 4'b1000}) begin
            errors++; $display("FAIL wrap_left: got page %0d blink %b want 3 1000", disp_page, blink);
        end
        hold_buttons(0, 1, 0, 0);
        checks++;
        if ({disp_page, blink} !== {2'd0, 4'b0001}) begin
            errors++; $display("FAIL wrap_right: got page %0d blink %b want 0 0001", disp_page, blink);
        end
        hold_buttons(1, 1, 0, 0);
        checks++;
        if ({disp_page, blink} !== {2'd0, 4'b0001}) begin
            errors++; $display("FAIL wrap_both: got page %0d blink %b want 0 0001", disp_page, blink);
        end
    endtask

    task automatic test_nibble();
        logic [63:0] want;
        do_reset();
        mode = 2'b01;
        hold_buttons(1, 0, 0, 0);
        hold_buttons(0, 0, 1, 0);
        hold_buttons(0, 0, 1, 0);
`ifdef CALC_CARRY_EN
        want = 64'h0123456789ABCDF1;
`else
        want = 64'h0123456789ABCDE1;
`endif
        cur_m = 0;
        b_m = inc_model(inc_model(b_m, 0), 0);
        checks += 3;
        if (b_op !== want) begin errors++; $display("FAIL nibble_b: got %h want %h", b_op, want); end
        if (disp_data !== want) begin errors++; $display("FAIL nibble_disp: got %h want %h", disp_data, want); end
        if (a_op !== a_m) begin errors++; $display("FAIL nibble_a_untouched: got %h want %h", a_op, a_m); end
    endtask

    task automatic test_random_edit();
        for (int it = 0; it < 24; it++) begin
            int act;
            logic [63:0] dwant;
            logic [3:0]  bwant;
            act  = int'($urandom_range(0, 3));
            mode = 2'($urandom_range(0, 3));
            case (act)
                0: begin hold_buttons(1, 0, 0, 0); cur_m = (cur_m + 15) % 16; end
                1: begin hold_buttons(0, 1, 0, 0); cur_m = (cur_m + 1) % 16; end
                2: begin
                    hold_buttons(0, 0, 1, 0);
                    if (mode == 2'b00) a_m = inc_model(a_m, cur_m);
                    if (mode == 2'b01) b_m = inc_model(b_m, cur_m);
                end
                default: hold_buttons(1, 1, 0, 0);
            endcase
            dwant = (mode == 2'b00) ? a_m : (mode == 2'b01) ? b_m : res_m;
            bwant = mode[1] ? 4'b0000 : 4'(1 << (cur_m % 4));
            checks += 5;
            if (a_op !== a_m) begin errors++; $display("FAIL rand_a[%0d]: got %h want %h", it, a_op, a_m); end
            if (b_op !== b_m) begin errors++; $display("FAIL rand_b[%0d]: got %h want %h", it, b_op, b_m); end
            if (disp_data !== dwant) begin
                errors++; $display("FAIL rand_disp[%0d]: got %h want %h", it, disp_data, dwant);
            end
            if (disp_page !== 2'(cur_m / 4)) begin
                errors++; $display("FAIL rand_page[%0d]: got %0d want %0d", it, disp_page, cur_m / 4);
            end
            if (blink !== bwant) begin errors++; $display("FAIL rand_blink[%0d]: got %b want %b", it, blink, bwant); end
        end
        mode = 2'b00;
    endtask

    task automatic test_handshake();
        int n = 0;
        mode = 2'b00; op_sel = 2'b10; btn_go = 1;
        while (alu_req !== 1'b1 && n < 20) begin tick(); n++; end
        checks++;
        if (alu_req !== 1'b1) begin errors++; $display("FAIL hs_req_rise: got %b want 1", alu_req); end
        btn_inc = 1;
        for (int k = 0; k < 3; k++) begin
            checks += 2;
            if (alu_req !== 1'b1) begin errors++; $display("FAIL hs_req_hold[%0d]: got %b want 1", k, alu_req); end
            if (busy !== 1'b1) begin errors++; $display("FAIL hs_busy_issue[%0d]: got %b want 1", k, busy); end
            if (k == 2) alu_ack = 1;
            tick();
        end
        alu_ack = 0;
        for (int k = 0; k < 5; k++) begin
            checks += 3;
            if (alu_req !== 1'b0) begin errors++; $display("FAIL hs_req_drop[%0d]: got %b want 0", k, alu_req); end
            if (busy !== 1'b1) begin errors++; $display("FAIL hs_busy_wait[%0d]: got %b want 1", k, busy); end
            if (blink !== 4'b0000) begin errors++; $display("FAIL hs_blink[%0d]: got %b want 0000", k, blink); end
            if (k == 4) begin
                alu_done = 1; alu_result = 64'h4000000000000000;
            end
            tick();
        end
        alu_done = 0;
        res_m = 64'h4000000000000000;
        checks += 5;
        if (result !== res_m) begin errors++; $display("FAIL hs_result: got %h want %h", result, res_m); end
        if (busy !== 1'b0) begin errors++; $display("FAIL hs_busy_show: got %b want 0", busy); end
        if (alu_op !== 2'b10) begin errors++; $display("FAIL hs_op: got %b want 10", alu_op); end
        if (a_op !== a_m) begin errors++; $display("FAIL hs_a_frozen: got %h want %h", a_op, a_m); end
        if (err !== 1'b0) begin errors++; $display("FAIL hs_err: got %b want 0", err); end
        alu_done = 1; alu_result = 64'h00000000DEADBEEF;
        tick();
        alu_done = 0;
        btn_go = 0; btn_inc = 0;
        cyc(DBL + 4);
        checks += 2;
        if (result !== res_m) begin errors++; $display("FAIL hs_stray_done: got %h want %h", result, res_m); end
        if (a_op !== a_m) begin errors++; $display("FAIL hs_a_after: got %h want %h", a_op, a_m); end
    endtask

    task automatic test_timeout();
        int n = 0;
        logic [1:0]  op2;
        logic [63:0] r;
        op_sel = 2'($urandom_range(0, 3)); btn_go = 1;
        while (alu_req !== 1'b1 && n < 20) begin tick(); n++; end
        alu_ack = 1; tick(); alu_ack = 0; btn_go = 0;
        n = 0;
        while (err !== 1'b1 && n < int'(TMO) + 20) begin tick(); n++; end
        checks += 4;
        if (err !== 1'b1 || n < int'(TMO) || n > int'(TMO) + 2) begin
            errors++; $display("FAIL to_err: got err %b after %0d cycles want 1 after ~%0d", err, n, TMO);
        end
        if (result !== res_m) begin errors++; $display("FAIL to_result: got %h want %h", result, res_m); end
        if (busy !== 1'b0) begin errors++; $display("FAIL to_busy: got %b want 0", busy); end
        if (alu_req !== 1'b0) begin errors++; $display("FAIL to_req: got %b want 0", alu_req); end
        op2 = 2'($urandom_range(0, 3)); op_sel = op2; btn_go = 1;
        n = 0;
        while (alu_req !== 1'b1 && n < 20) begin tick(); n++; end
        checks += 2;
        if (alu_req !== 1'b1) begin errors++; $display("FAIL to_reissue: got %b want 1", alu_req); end
        if (err !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %b want 0", err); end
        alu_ack = 1; tick(); alu_ack = 0;
        r = {$urandom(), $urandom()};
        alu_done = 1; alu_result = r; tick(); alu_done = 0;
        res_m = r;
        btn_go = 0;
        cyc(DBL + 4);
        checks += 2;
        if (result !== res_m) begin errors++; $display("FAIL to_result2: got %h want %h", result, res_m); end
        if (alu_op !== op2) begin errors++; $display("FAIL to_op2: got %b want %b", alu_op, op2); end
    endtask

    task automatic test_async_reset();
        int n = 0;
        mode = 2'b00;
        hold_buttons(0, 0, 1, 0);
        a_m = inc_model(a_m, cur_m);
        checks++;
        if (a_op !== a_m) begin errors++; $display("FAIL ar_pre_a: got %h want %h", a_op, a_m); end
        btn_go = 1;
        while (alu_req !== 1'b1 && n < 20) begin tick(); n++; end
        alu_ack = 1; tick(); alu_ack = 0;
        cyc(3);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL ar_in_wait: got busy %b want 1", busy); end
        #2 rst_n = 0;
        #1;
        checks += 6;
        if (alu_req !== 1'b0) begin errors++; $display("FAIL ar_req: got %b want 0", alu_req); end
        if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy: got %b want 0", busy); end
        if (a_op !== 64'hFEDCBA9876543210) begin errors++; $display("FAIL ar_a: got %h want FEDCBA9876543210", a_op); end
        if (b_op !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL ar_b: got %h want 0123456789ABCDEF", b_op); end
        if (result !== 64'd0) begin errors++; $display("FAIL ar_result: got %h want 0", result); end
        if ({disp_page, blink} !== {2'd0, 4'b0010}) begin
            errors++; $display("FAIL ar_cursor: got page %0d blink %b want 0 0010", disp_page, blink);
        end
        btn_go = 0;
        tick();
        rst_n = 1;
        tick();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_bounce();
        test_wrap();
        test_nibble();
        test_random_edit();
        test_handshake();
        test_timeout();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
